ds_frame_unpack: RTL

DS_FRAME_UNPACK -- requirements
Module: ds_frame_unpack

---
 rtl/ds_frame_unpack.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ds_frame_unpack.sv
// ds_frame_unpack: parses downstream UDP frames into run control, command
// words and per-sample LR / IQ byte streams. It also tracks sequence gaps and
// runs a watchdog that stops streaming when data packets stop arriving.
module ds_frame_unpack #(
    parameter int NIQ    = 1,
    parameter int NSUB   = 2,
    parameter int NSAMP  = 63,
    parameter int WDOG_W = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        eth_valid,
    input  logic [7:0]  eth_data,
    input  logic [15:0] eth_port,
    input  logic        watchdog_up,
    output logic        run,
    output logic [5:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic [1:0]  cmd_mask,
    output logic        cmd_ptt,
    output logic        cmd_cnt,
    output logic        lr_tvalid,
    output logic        lr_tlast,
    output logic        iq_tvalid,
    output logic        iq_tlast,
    output logic [1:0]  iq_tuser,
    output logic [7:0]  tdata,
    output logic [15:0] seq_err_cnt,
    output logic        frame_err
);

    typedef enum logic [3:0] {
        IDLE, PRE, TYPE, RUNSTOP, EP, SEQ, SYNC, CMD, LR, IQ, SKIP
    } state_t;

    localparam logic [3:0] IQ_LAST   = 4'(4 * NIQ - 1);
    localparam logic [7:0] SAMP_LAST = 8'(NSAMP - 1);
    localparam logic [7:0] SUB_LAST  = 8'(NSUB - 1);

    state_t              state_q;
    logic [3:0]          byte_q;
    logic [7:0]          samp_q;
    logic [7:0]          sub_q;
    logic                valid_q;
    logic                run_q;
    logic [23:0]         seq_rx_q;
    logic [31:0]         seq_last_q;
    logic                seq_valid_q;
    logic [15:0]         seq_err_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic [1:0]          mask_tmp_q;
    logic [5:0]          addr_tmp_q;
    logic                ptt_tmp_q;
    logic [23:0]         data_tmp_q;
    logic [5:0]          cmd_addr_q;
    logic [31:0]         cmd_data_q;
    logic [1:0]          cmd_mask_q;
    logic                cmd_ptt_q;
    logic                cmd_cnt_q;
    logic                frame_err_q;

    logic [31:0]         seq_rx_d;
    logic [31:0]         cmd_data_d;
    logic                sync_ok_d;
    logic                port_ok;
    logic                seq_done;
    logic                wdog_expire;
    logic                in_body;
    logic                unused_port_lsb;

    // Port LSB is a don't-care: both ports of the 1024/1025 pair are accepted.
    assign unused_port_lsb = eth_port[0];
    assign port_ok     = (eth_port[15:1] == 15'd512);
    assign seq_rx_d    = {seq_rx_q, eth_data};
    assign cmd_data_d  = {data_tmp_q, eth_data};
    assign seq_done    = (state_q == SEQ) && eth_valid && (byte_q[1:0] == 2'd3);
    assign wdog_expire = run_q && (wdog_q == '1);
    assign in_body     = (state_q == SEQ) || (state_q == SYNC) || (state_q == CMD) ||
                         (state_q == LR)  || (state_q == IQ);

    // Validates the current sync byte: two 7F markers, then six ones above the mask.
    always_comb begin
        sync_ok_d = 1'b0;
        case (byte_q)
            4'd0, 4'd1: sync_ok_d = (eth_data == 8'h7F);
            4'd2:       sync_ok_d = (eth_data[7:2] == 6'h3F);
            default:    sync_ok_d = 1'b0;
        endcase
    end

    // Packet parser, command latch, sequence tracking and watchdog in one registered FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            samp_q      <= '0;
            sub_q       <= '0;
            valid_q     <= 1'b1;
            run_q       <= 1'b0;
            seq_rx_q    <= '0;
            seq_last_q  <= '0;
            seq_valid_q <= 1'b0;
            seq_err_q   <= '0;
            wdog_q      <= '0;
            mask_tmp_q  <= 2'b11;
            addr_tmp_q  <= '0;
            ptt_tmp_q   <= 1'b0;
            data_tmp_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_mask_q  <= 2'b11;
            cmd_ptt_q   <= 1'b0;
            cmd_cnt_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= eth_valid;
            frame_err_q <= 1'b0;

            if (!run_q || wdog_expire || seq_done) begin
                wdog_q <= '0;
            end else if (watchdog_up) begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end

            if (state_q != IDLE && !eth_valid) begin
                state_q     <= IDLE;
                byte_q      <= '0;
                frame_err_q <= in_body;
            end else begin
                case (state_q)
                    IDLE: begin
                        byte_q <= '0;
                        // valid_q high means we are inside a packet we chose to ignore.
                        if (eth_valid && !valid_q) begin
                            state_q <= (port_ok && eth_data == 8'hEF) ? PRE : SKIP;
                        end
                    end
                    PRE: state_q <= (eth_data == 8'hFE) ? TYPE : SKIP;
                    TYPE: begin
                        if (eth_data == 8'h04)      state_q <= RUNSTOP;
                        else if (eth_data == 8'h01) state_q <= EP;
                        else                        state_q <= SKIP;
                    end
                    RUNSTOP: begin
                        run_q   <= eth_data[0];
                        state_q <= SKIP;
                    end
                    EP: begin
                        byte_q  <= '0;
                        samp_q  <= '0;
                        sub_q   <= '0;
                        state_q <= (eth_data == 8'h02) ? SEQ : SKIP;
                    end
                    SEQ: begin
                        seq_rx_q <= seq_rx_d[23:0];
                        if (byte_q[1:0] == 2'd3) begin
                            if (seq_valid_q && (seq_rx_d != seq_last_q + 32'd1) &&
                                (seq_err_q != 16'hFFFF)) begin
                                seq_err_q <= seq_err_q + 16'd1;
                            end
                            seq_last_q  <= seq_rx_d;
                            seq_valid_q <= 1'b1;
                            byte_q      <= '0;
                            state_q     <= SYNC;
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                    SYNC: begin
                        if (!sync_ok_d) begin
                            frame_err_q <= 1'b1;
                            state_q     <= SKIP;
                        end else if (byte_q == 4'd2) begin
                            mask_tmp_q <= eth_data[1:0];
                            byte_q     <= '0;
                            state_q    <= CMD;
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                    CMD: begin
                        if (byte_q == 4'd0) begin
                            addr_tmp_q <= eth_data[6:1];
                            ptt_tmp_q  <= eth_data[0];
                        end else begin
                            data_tmp_q <= cmd_data_d[23:0];
                        end
                        if (byte_q == 4'd4) begin
                            cmd_addr_q <= addr_tmp_q;
                            cmd_data_q <= cmd_data_d;
                            cmd_mask_q <= mask_tmp_q;
                            cmd_ptt_q  <= ptt_tmp_q;
                            cmd_cnt_q  <= ~cmd_cnt_q;
                            byte_q     <= '0;
                            state_q    <= LR;
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                    LR: begin
                        if (byte_q == 4'd3) begin
                            byte_q  <= '0;
                            state_q <= IQ;
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                    IQ: begin
                        if (byte_q == IQ_LAST) begin
                            byte_q <= '0;
                            if (samp_q == SAMP_LAST) begin
                                samp_q <= '0;
                                if (sub_q == SUB_LAST) begin
                                    sub_q   <= '0;
                                    state_q <= SKIP;
                                end else begin
                                    sub_q   <= sub_q + 8'd1;
                                    state_q <= SYNC;
                                end
                            end else begin
                                samp_q  <= samp_q + 8'd1;
                                state_q <= LR;
                            end
                        end else begin
                            byte_q <= byte_q + 4'd1;
                        end
                    end
                    SKIP:    state_q <= SKIP;
                    default: state_q <= IDLE;
                endcase
            end

            // Expiry wins over a same-cycle RUNSTOP write and any parser progress.
            if (wdog_expire) begin
                run_q   <= 1'b0;
                state_q <= IDLE;
                byte_q  <= '0;
            end

            // Forget the last sequence number while stopped so a restart is never a gap.
            if (!run_q) begin
                seq_valid_q <= 1'b0;
            end
        end
    end

    assign run         = run_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_data    = cmd_data_q;
    assign cmd_mask    = cmd_mask_q;
    assign cmd_ptt     = cmd_ptt_q;
    assign cmd_cnt     = cmd_cnt_q;
    assign seq_err_cnt = seq_err_q;
    assign frame_err   = frame_err_q;
    assign tdata       = eth_data;

    assign lr_tvalid = rst_n && eth_valid && (state_q == LR);
    assign lr_tlast  = lr_tvalid && (byte_q == 4'd3);
    assign iq_tvalid = rst_n && eth_valid && (state_q == IQ) && cmd_ptt_q;
    assign iq_tlast  = iq_tvalid && (byte_q[1:0] == 2'd3);
    assign iq_tuser  = iq_tvalid ? byte_q[3:2] : 2'b00;

endmodule
